// File: rtl/lbist_ctrl.sv
// lbist_ctrl: logic BIST controller for the core-under-test.
// Holds the CUT in reset under test mode, streams Galois-LFSR patterns into it,
// folds the delayed responses into a MISR, and flags the final signature
// against GOLDEN_SIG.
module lbist_ctrl #(
   parameter logic [31:0] LFSR_SEED      = 32'h0000_0001,
   parameter logic [31:0] LFSR_POLY      = 32'h8020_0003,
   parameter int          N_PATTERNS     = 1024,
   parameter int          CUT_RST_CYCLES = 4,
   parameter int          RESP_LATENCY   = 1,
   parameter logic [31:0] GOLDEN_SIG     = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        test_mode_o,
   output logic        cut_rst_no,
   output logic [31:0] pattern_o,
   output logic        pattern_valid_o,
   input  logic [31:0] resp_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [31:0] signature_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CUT_RST = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_FLUSH   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   // Pattern counter is sized to hold N_PATTERNS so it saturates instead of wrapping.
   localparam int PCW    = $clog2(N_PATTERNS + 1);
   // Phase counter is shared by CUT_RST and FLUSH; FLUSH never exceeds 7 cycles.
   localparam int CW_MAX = (CUT_RST_CYCLES > 8) ? CUT_RST_CYCLES : 8;
   localparam int CW     = $clog2(CW_MAX + 1);

   localparam logic [PCW-1:0] PAT_LAST   = PCW'(N_PATTERNS - 1);
   localparam logic [CW-1:0]  RST_LAST   = CW'(CUT_RST_CYCLES - 1);
   localparam logic [CW-1:0]  FLUSH_LAST = CW'((RESP_LATENCY == 0) ? 0 : RESP_LATENCY - 1);

   // Reject configurations that would lock up the LFSR or the sequencer.
   generate
      if (LFSR_SEED == 32'h0) begin : g_bad_seed
         $fatal(1, "lbist_ctrl: LFSR_SEED must be non-zero");
      end
      if (N_PATTERNS < 1) begin : g_bad_npat
         $fatal(1, "lbist_ctrl: N_PATTERNS must be >= 1");
      end
      if (CUT_RST_CYCLES < 1) begin : g_bad_rst
         $fatal(1, "lbist_ctrl: CUT_RST_CYCLES must be >= 1");
      end
      if (RESP_LATENCY < 0 || RESP_LATENCY > 7) begin : g_bad_lat
         $fatal(1, "lbist_ctrl: RESP_LATENCY must be in 0..7");
      end
   endgenerate

   function automatic logic [31:0] galois_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
   endfunction

   logic [2:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [PCW-1:0] pat_cnt_q, pat_cnt_d;
   logic [31:0]    lfsr_q, lfsr_d;
   logic [31:0]    misr_q, misr_d;
   logic           pattern_valid;
   logic           resp_valid;

   assign pattern_valid = (state_q == S_RUN);

   // Response-valid is the pattern strobe delayed by the CUT's response latency.
   generate
      if (RESP_LATENCY == 0) begin : g_no_pipe
         assign resp_valid = pattern_valid;
      end else begin : g_pipe
         logic [RESP_LATENCY-1:0] vld_pipe_q, vld_pipe_d;

         // Shift the pattern strobe one stage per cycle.
         always_comb begin
            vld_pipe_d    = vld_pipe_q;
            vld_pipe_d[0] = pattern_valid;
            for (int i = 1; i < RESP_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
         end

         // Pipeline state; cleared on reset so an aborted session leaves no strays.
         always_ff @(posedge clk_i) begin
            if (rst_i) vld_pipe_q <= '0;
            else       vld_pipe_q <= vld_pipe_d;
         end

         assign resp_valid = vld_pipe_q[RESP_LATENCY-1];
      end
   endgenerate

   // Sequencer, TPG and MISR next-state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pat_cnt_d = pat_cnt_q;
      lfsr_d    = lfsr_q;
      misr_d    = misr_q;
      if (resp_valid) misr_d = galois_step(misr_q) ^ resp_i;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d   = S_CUT_RST;
               cnt_d     = '0;
               pat_cnt_d = '0;
               lfsr_d    = LFSR_SEED;
               misr_d    = '0;
            end
         end
         S_CUT_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            lfsr_d    = galois_step(lfsr_q);
            pat_cnt_d = pat_cnt_q + PCW'(1);
            if (pat_cnt_q == PAT_LAST) begin
               cnt_d   = '0;
               state_d = (RESP_LATENCY == 0) ? S_DONE : S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (cnt_q == FLUSH_LAST) state_d = S_DONE;
            else                     cnt_d   = cnt_q + CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any session back to IDLE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pat_cnt_q <= '0;
         lfsr_q    <= LFSR_SEED;
         misr_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pat_cnt_q <= pat_cnt_d;
         lfsr_q    <= lfsr_d;
         misr_q    <= misr_d;
      end
   end

   // Test mode stays on in DONE so the CUT is not released mid-readout.
   assign test_mode_o     = (state_q != S_IDLE);
   assign cut_rst_no      = (state_q != S_CUT_RST);
   assign pattern_o       = lfsr_q;
   assign pattern_valid_o = pattern_valid;
   assign busy_o          = (state_q == S_CUT_RST) || (state_q == S_RUN) || (state_q == S_FLUSH);
   assign done_o          = (state_q == S_DONE);
   assign pass_o          = (state_q == S_DONE) && (misr_q == GOLDEN_SIG);
   assign signature_o     = misr_q;

endmodule
